// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU operation codes, operand-source
// selects and the ID/EX pipeline record.
package riscv_pkg;

  localparam int WORD_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_ctl_t;

  typedef enum logic [1:0] {
    SRC_RS2  = 2'b00,
    SRC_IMM  = 2'b01,
    SRC_FOUR = 2'b10
  } alu_bsrc_t;

  typedef enum logic {
    SRC_RS1 = 1'b0,
    SRC_PC  = 1'b1
  } alu_asrc_t;

  typedef struct packed {
    logic              valid;
    alu_asrc_t         asrc;
    alu_bsrc_t         bsrc;
    alu_ctl_t          actl;
    logic [WORD_W-1:0] rdata1;
    logic [WORD_W-1:0] rdata2;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              jump_reg;
    logic              illegal;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ALU operand/control bundle between the ID/EX register and the EX stage.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic              ex_valid;
  logic              ALUASrc;
  logic [1:0]        ALUBSrc;
  logic [3:0]        ALUCtl;
  logic [WORD_W-1:0] ReadData1;
  logic [WORD_W-1:0] ReadData2;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] ImmGenOut;
  logic [4:0]        ex_rd;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [2:0]        ex_funct3;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic              Branch;
  logic              Jump;
  logic              JumpReg;
  logic              ex_illegal;

  modport master (
    output ex_valid, ALUASrc, ALUBSrc, ALUCtl, ReadData1, ReadData2, pc, ImmGenOut,
           ex_rd, ex_rs1, ex_rs2, ex_funct3, RegWrite, MemRead, MemWrite, Branch,
           Jump, JumpReg, ex_illegal
  );

  modport slave (
    input ex_valid, ALUASrc, ALUBSrc, ALUCtl, ReadData1, ReadData2, pc, ImmGenOut,
          ex_rd, ex_rs1, ex_rs2, ex_funct3, RegWrite, MemRead, MemWrite, Branch,
          Jump, JumpReg, ex_illegal
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J format from the
// opcode and sign-extends to 32 bits.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] imm
);

  logic [WORD_W-1:0] imm_i;
  logic [WORD_W-1:0] imm_s;
  logic [WORD_W-1:0] imm_b;
  logic [WORD_W-1:0] imm_u;
  logic [WORD_W-1:0] imm_j;
  logic              is_shift;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shift-immediates carry funct7 in the upper bits; only the shamt is an operand.
  assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OP_IMM:          imm = is_shift ? {27'b0, instr[24:20]} : imm_i;
      OPC_LOAD, OPC_JALR:  imm = imm_i;
      OPC_STORE:           imm = imm_s;
      OPC_BRANCH:          imm = imm_b;
      OPC_LUI, OPC_AUIPC:  imm = imm_u;
      OPC_JAL:             imm = imm_j;
      default:             imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode plus ID/EX pipeline register, with load-use bubble insertion
// and downstream hold/flush handling.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = WORD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr,
  input  logic [XLEN-1:0] if_id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            hold,
  input  logic            flush,
  output logic            id_stall,
  id_ex_stage_if.master   ex
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   imm;
  logic              use_rs1;
  logic              use_rs2;
  logic              dec_illegal;
  logic              hazard;
  id_ex_t            decoded;
  id_ex_t            id_ex_reg;
  id_ex_t            id_ex_next;

  assign opcode   = if_id_instr[6:0];
  assign funct3   = if_id_instr[14:12];
  assign rs1_addr = (opcode == OPC_LUI) ? 5'd0 : if_id_instr[19:15];
  assign rs2_addr = if_id_instr[24:20];

  imm_gen u_imm_gen (
    .instr (if_id_instr),
    .imm   (imm)
  );

  always_comb begin
    decoded        = '0;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    dec_illegal    = 1'b0;
    decoded.valid  = 1'b1;
    decoded.asrc   = SRC_RS1;
    decoded.bsrc   = SRC_RS2;
    decoded.actl   = ALU_ADD;
    decoded.rdata1 = rf_rdata1;
    decoded.rdata2 = rf_rdata2;
    decoded.pc     = if_id_pc;
    decoded.imm    = imm;
    decoded.funct3 = funct3;
    case (opcode)
      OPC_OP: begin
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
        decoded.reg_write = 1'b1;
        decoded.actl      = alu_ctl_t'({if_id_instr[30], funct3});
      end
      OPC_OP_IMM: begin
        use_rs1           = 1'b1;
        decoded.reg_write = 1'b1;
        decoded.bsrc      = SRC_IMM;
        decoded.actl      = alu_ctl_t'({(funct3 == 3'b101) & if_id_instr[30], funct3});
      end
      OPC_LOAD: begin
        use_rs1           = 1'b1;
        decoded.reg_write = 1'b1;
        decoded.mem_read  = 1'b1;
        decoded.bsrc      = SRC_IMM;
      end
      OPC_STORE: begin
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
        decoded.mem_write = 1'b1;
        decoded.bsrc      = SRC_IMM;
      end
      OPC_BRANCH: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        decoded.branch = 1'b1;
        case (funct3[2:1])
          2'b10:   decoded.actl = ALU_SLT;
          2'b11:   decoded.actl = ALU_SLTU;
          default: decoded.actl = ALU_SUB;
        endcase
      end
      OPC_JAL: begin
        decoded.reg_write = 1'b1;
        decoded.jump      = 1'b1;
        decoded.asrc      = SRC_PC;
        decoded.bsrc      = SRC_FOUR;
      end
      OPC_JALR: begin
        use_rs1           = 1'b1;
        decoded.reg_write = 1'b1;
        decoded.jump      = 1'b1;
        decoded.jump_reg  = 1'b1;
        decoded.asrc      = SRC_PC;
        decoded.bsrc      = SRC_FOUR;
      end
      OPC_LUI: begin
        decoded.reg_write = 1'b1;
        decoded.bsrc      = SRC_IMM;
      end
      OPC_AUIPC: begin
        decoded.reg_write = 1'b1;
        decoded.asrc      = SRC_PC;
        decoded.bsrc      = SRC_IMM;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Indices of unused fields are zeroed so forwarding logic never matches them.
    decoded.rd  = decoded.reg_write ? if_id_instr[11:7] : 5'd0;
    decoded.rs1 = use_rs1 ? rs1_addr : 5'd0;
    decoded.rs2 = use_rs2 ? rs2_addr : 5'd0;
  end

  assign hazard = id_ex_reg.valid & id_ex_reg.mem_read & (id_ex_reg.rd != 5'd0) & if_id_valid &
                  ((use_rs1 & (id_ex_reg.rd == rs1_addr)) | (use_rs2 & (id_ex_reg.rd == rs2_addr)));

  assign id_stall = ~flush & (hold | hazard);

  // Priority: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    id_ex_next = '0;
    if (!flush) begin
      if (hold) begin
        id_ex_next = id_ex_reg;
      end else if (if_id_valid && !hazard) begin
        if (dec_illegal) begin
          id_ex_next.illegal = 1'b1;
        end else begin
          id_ex_next = decoded;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_reg <= '0;
    end else begin
      id_ex_reg <= id_ex_next;
    end
  end

  assign ex.ex_valid   = id_ex_reg.valid;
  assign ex.ALUASrc    = id_ex_reg.asrc;
  assign ex.ALUBSrc    = id_ex_reg.bsrc;
  assign ex.ALUCtl     = id_ex_reg.actl;
  assign ex.ReadData1  = id_ex_reg.rdata1;
  assign ex.ReadData2  = id_ex_reg.rdata2;
  assign ex.pc         = id_ex_reg.pc;
  assign ex.ImmGenOut  = id_ex_reg.imm;
  assign ex.ex_rd      = id_ex_reg.rd;
  assign ex.ex_rs1     = id_ex_reg.rs1;
  assign ex.ex_rs2     = id_ex_reg.rs2;
  assign ex.ex_funct3  = id_ex_reg.funct3;
  assign ex.RegWrite   = id_ex_reg.reg_write;
  assign ex.MemRead    = id_ex_reg.mem_read;
  assign ex.MemWrite   = id_ex_reg.mem_write;
  assign ex.Branch     = id_ex_reg.branch;
  assign ex.Jump       = id_ex_reg.jump;
  assign ex.JumpReg    = id_ex_reg.jump_reg;
  assign ex.ex_illegal = id_ex_reg.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ID/EX contents are queued when an
// instruction is driven and compared one clock later.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [3:0]  actl;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        regw;
    logic        memr;
    logic        memw;
    logic        br;
    logic        jmp;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        hold;
  logic        flush;
  logic        id_stall;

  int checks = 0;
  int errors = 0;
  int txn    = 0;
  exp_t sb[$];
  exp_t held;

  id_ex_stage_if ex_if ();

  id_ex_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .hold        (hold),
    .flush       (flush),
    .id_stall    (id_stall),
    .ex          (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(logic valid, logic [3:0] actl, logic asrc, logic [1:0] bsrc,
                              logic [31:0] rd1, logic [31:0] rd2, logic [31:0] pcv,
                              logic [31:0] imm, logic [4:0] rd, logic regw, logic memr,
                              logic memw, logic br, logic jmp, logic ill);
    exp_t e;
    e.valid = valid; e.actl = actl; e.asrc = asrc; e.bsrc = bsrc;
    e.rd1 = rd1; e.rd2 = rd2; e.pc = pcv; e.imm = imm; e.rd = rd;
    e.regw = regw; e.memr = memr; e.memw = memw; e.br = br; e.jmp = jmp; e.ill = ill;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      txn++;
      $display("txn %0d pc=%h ex_valid=%0b ALUCtl=%h ImmGenOut=%h ex_illegal=%0b",
               txn, ex_if.pc, ex_if.ex_valid, ex_if.ALUCtl, ex_if.ImmGenOut, ex_if.ex_illegal);
      check("ex_valid",   32'(ex_if.ex_valid),   32'(e.valid));
      check("ALUCtl",     32'(ex_if.ALUCtl),     32'(e.actl));
      check("ALUASrc",    32'(ex_if.ALUASrc),    32'(e.asrc));
      check("ALUBSrc",    32'(ex_if.ALUBSrc),    32'(e.bsrc));
      check("ReadData1",  ex_if.ReadData1,       e.rd1);
      check("ReadData2",  ex_if.ReadData2,       e.rd2);
      check("pc",         ex_if.pc,              e.pc);
      check("ImmGenOut",  ex_if.ImmGenOut,       e.imm);
      check("RegWrite",   32'(ex_if.RegWrite),   32'(e.regw));
      check("MemRead",    32'(ex_if.MemRead),    32'(e.memr));
      check("MemWrite",   32'(ex_if.MemWrite),   32'(e.memw));
      check("Branch",     32'(ex_if.Branch),     32'(e.br));
      check("Jump",       32'(ex_if.Jump),       32'(e.jmp));
      check("ex_illegal", 32'(ex_if.ex_illegal), 32'(e.ill));
      if (e.regw) check("ex_rd", 32'(ex_if.ex_rd), 32'(e.rd));
    end
  endtask

  // Drive one IF/ID slot at the falling edge, check the combinational outputs,
  // queue the expectation and compare right after the next rising edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] pcv,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic v, input logic h, input logic f,
                      input logic exp_stall, input logic [4:0] exp_rs1a, input exp_t e);
    @(negedge clk);
    if_id_valid = v;
    if_id_instr = instr;
    if_id_pc    = pcv;
    rf_rdata1   = d1;
    rf_rdata2   = d2;
    hold        = h;
    flush       = f;
    #1;
    check("id_stall", 32'(id_stall), 32'(exp_stall));
    check("rs1_addr", 32'(rs1_addr), 32'(exp_rs1a));
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    exp_t bub;
    exp_t add8;
    bub  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add8 = mk(1, 4'h0, 0, 2'b00, 32'h77, 32'h77, 32'h20, 0, 8, 1, 0, 0, 0, 0, 0);

    rst_n = 1'b0; if_id_valid = 1'b0; if_id_instr = '0; if_id_pc = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; hold = 1'b0; flush = 1'b0;
    #2;
    check("rst_ex_valid",   32'(ex_if.ex_valid),   32'd0);
    check("rst_RegWrite",   32'(ex_if.RegWrite),   32'd0);
    check("rst_ex_illegal", 32'(ex_if.ex_illegal), 32'd0);
    check("rst_ReadData1",  ex_if.ReadData1,       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // add x3,x1,x2
    step(32'h002081B3, 32'h10, 10, 20, 1, 0, 0, 0, 1,
         mk(1, 4'h0, 0, 2'b00, 10, 20, 32'h10, 0, 3, 1, 0, 0, 0, 0, 0));
    // srai x5,x6,2
    step(32'h40235293, 32'h14, 100, 0, 1, 0, 0, 0, 6,
         mk(1, 4'hD, 0, 2'b01, 100, 0, 32'h14, 2, 5, 1, 0, 0, 0, 0, 0));
    // sw x2,-4(x1)
    step(32'hFE20AE23, 32'h18, 32'h1000, 32'h55, 1, 0, 0, 0, 1,
         mk(1, 4'h0, 0, 2'b01, 32'h1000, 32'h55, 32'h18, 32'hFFFFFFFC, 0, 0, 0, 1, 0, 0, 0));
    // lw x7,0(x1), then dependent add x8,x7,x7: one bubble, then the add
    step(32'h0000A383, 32'h1C, 32'h2000, 0, 1, 0, 0, 0, 1,
         mk(1, 4'h0, 0, 2'b01, 32'h2000, 0, 32'h1C, 0, 7, 1, 1, 0, 0, 0, 0));
    step(32'h00738433, 32'h20, 32'h77, 32'h77, 1, 0, 0, 1, 7, bub);
    step(32'h00738433, 32'h20, 32'h77, 32'h77, 1, 0, 0, 0, 7, add8);

    // hold for three cycles: the add stays put while addi x9,x0,5 waits
    held = add8;
    for (int i = 0; i < 3; i++) begin
      step(32'h00500493, 32'h24, 0, 0, 1, 1, 0, 1, 0, held);
    end
    step(32'h00500493, 32'h24, 0, 0, 1, 0, 0, 0, 0,
         mk(1, 4'h0, 0, 2'b01, 0, 0, 32'h24, 5, 9, 1, 0, 0, 0, 0, 0));

    // flush wins over hold
    step(32'h002081B3, 32'h28, 1, 2, 1, 1, 1, 0, 1, bub);

    // all-zero opcode is illegal: one-cycle flag, then lui clears it
    step(32'h00000000, 32'h2C, 0, 0, 1, 0, 0, 0, 0,
         mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(32'h12345537, 32'h30, 0, 0, 1, 0, 0, 0, 0,
         mk(1, 4'h0, 0, 2'b01, 0, 0, 32'h30, 32'h12345000, 10, 1, 0, 0, 0, 0, 0));

    // jal x1,8 and blt x1,x2,+8
    step(32'h008000EF, 32'h40, 0, 0, 1, 0, 0, 0, 0,
         mk(1, 4'h0, 1, 2'b10, 0, 0, 32'h40, 8, 1, 1, 0, 0, 0, 1, 0));
    step(32'h0020C463, 32'h44, 5, 9, 1, 0, 0, 0, 1,
         mk(1, 4'h2, 0, 2'b00, 5, 9, 32'h44, 8, 0, 0, 0, 0, 1, 0, 0));

    // invalid slot captures a bubble
    step(32'h002081B3, 32'h48, 3, 4, 0, 0, 0, 0, 1, bub);
    step(32'h0020C463, 32'h4C, 5, 9, 1, 0, 0, 0, 1,
         mk(1, 4'h2, 0, 2'b00, 5, 9, 32'h4C, 8, 0, 0, 0, 0, 1, 0, 0));

    // asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid",  32'(ex_if.ex_valid), 32'd0);
    check("arst_ALUCtl",    32'(ex_if.ALUCtl),   32'd0);
    check("arst_Branch",    32'(ex_if.Branch),   32'd0);
    check("arst_ReadData1", ex_if.ReadData1,     32'd0);
    check("arst_ImmGenOut", ex_if.ImmGenOut,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h002081B3, 32'h50, 10, 20, 1, 0, 0, 0, 1,
         mk(1, 4'h0, 0, 2'b00, 10, 20, 32'h50, 0, 3, 1, 0, 0, 0, 0, 0));

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode and ID/EX pipeline-register stage of the five-stage RV32I core. It is the producing end of the ALU operand/control interface: it turns the IF/ID instruction word into `ALUASrc`/`ALUBSrc`/`ALUCtl`/`ImmGenOut` plus operands and registers them for EX. It also detects load-use hazards, inserts bubbles, and honours downstream hold and flush.

## Interface
- `XLEN`, 32, datapath width (only 32 is supported).
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `if_id_valid`  in  1  IF/ID slot holds a real instruction.
- `if_id_instr`  in  32  instruction word.
- `if_id_pc`  in  32  PC of that instruction.
- `rs1_addr`, `rs2_addr`  out  5  register-file read addresses (combinational from instr).
- `rf_rdata1`, `rf_rdata2`  in  32  register-file read data for `rs1_addr`/`rs2_addr`.
- `hold`  in  1  downstream stall: freeze ID/EX.
- `flush`  in  1  taken branch/jump from EX: kill ID/EX contents.
- `id_stall`  out  1  freeze PC and IF/ID (combinational).
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `ALUASrc`  out  1  0 = `ReadData1`, 1 = `pc`.
- `ALUBSrc`  out  2  00 = `ReadData2`, 01 = `ImmGenOut`, 10 = constant 4.
- `ALUCtl`  out  4  ALU operation code.
- `ReadData1`, `ReadData2`, `pc`, `ImmGenOut`  out  32  registered operands.
- `ex_rd`, `ex_rs1`, `ex_rs2`  out  5  registered register indices.
- `ex_funct3`  out  3  registered funct3 (branch/load/store width).
- `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `Jump`, `JumpReg`  out  1  registered controls.
- `ex_illegal`  out  1  an unsupported opcode was decoded (one-cycle flag).

## Operation
- ALUCtl codes: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
- OP: ASrc 0, BSrc 00, ALUCtl = {funct7[5], funct3}.
- OP-IMM: ASrc 0, BSrc 01, ALUCtl = {funct3==101 ? funct7[5] : 0, funct3}.
- LOAD/STORE: add, ASrc 0, BSrc 01. MemRead is 1 for LOAD; MemWrite is 1 for STORE, which has RegWrite 0.
- BRANCH: ASrc 0, BSrc 00. beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu. Branch is 1 and RegWrite is 0.
- JAL/JALR: ASrc 1, BSrc 10, add (link value pc+4). Jump is 1; JumpReg is 1 for JALR only.
- LUI: `rs1_addr` forced to 0, ASrc 0, BSrc 01, add.
- AUIPC: ASrc 1, BSrc 01, add.
- Immediates use I/S/B/U/J formats, are sign-extended to 32 bits, and come out as `ImmGenOut`. U-type is imm[31:12]<<12.
- Load-use hazard: `ex_valid & MemRead & ex_rd!=0 & if_id_valid & (ex_rd==rs1_addr | ex_rd==rs2_addr)`. Only fields the instruction actually uses are compared.
- Illegal opcode: the stage captures a bubble and sets `ex_illegal` to 1 for one cycle.

## Timing
- Reset: every registered output is 0, which includes `ex_valid`, all controls and `ex_illegal`.
- Latency: an instruction present on a rising edge appears on the outputs after that edge (1 cycle).
- Per-edge priority:
  - `flush` set: capture a bubble, even if `hold` or a hazard is also present.
  - else `hold` set: keep all registers unchanged.
  - else hazard set: capture a bubble.
  - else: capture the decode.
- A bubble means `ex_valid`=0 and every control is 0. Operand registers are don't-care but are driven to 0.
- `id_stall` = ~flush & (hold | hazard).
- `if_id_valid`=0 captures a bubble.
- A load-use pair costs exactly one bubble cycle. On the next edge the load has moved on and the dependent instruction is captured.
- Reset asserted mid-operation clears state immediately, asynchronously.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants;
  - ALUCtl encodings;
  - ALUBSrc encodings (SRC_RS2, SRC_IMM, SRC_FOUR);
  - ALUASrc encodings.
- Sub-module `imm_gen` (combinational, instr → ImmGenOut).
- Decode, hazard detection and the pipeline register live in `id_ex_stage`.

## Test plan
- add x3,x1,x2 (0x002081B3), pc 0x10, rdata 10/20 → next edge:
  - ex_valid 1, ALUCtl 0000, ASrc 0, BSrc 00;
  - ReadData1 10, ReadData2 20, ex_rd 3, RegWrite 1.
- srai x5,x6,2 (0x40235293) → ALUCtl 1101, BSrc 01, ImmGenOut 2, ex_rd 5.
- sw x2,-4(x1) (0xFE20AE23) → ImmGenOut 0xFFFFFFFC, ALUCtl 0000, MemWrite 1, RegWrite 0.
- lw x7,0(x1) (0x0000A383) then add x8,x7,x7 (0x00738433):
  - id_stall is 1 for one cycle and a bubble is inserted (ex_valid 0);
  - the add is captured on the following edge.
- hold=1 → outputs frozen for 3 cycles.
- flush=1 together with hold=1 → ex_valid 0 after the edge and id_stall 0.
- Opcode 0x00000000 → ex_valid 0 and ex_illegal 1 for one cycle.
- rst_n pulsed low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
